io_uart_txq: RTL and testbench

- Transmit-queue controller between the CPU IO port (IO_mem_* bus) and the byte-wide UART emitter (valid/ready byte interface).
- Accepts byte writes from the CPU into a FIFO and drains it into the emitter at line rate. The CPU only stalls-polls when the queue is full, not on every byte.
- Provides the IO status word, replacing the SOC's direct "!uart_ready" status readback.

---
 rtl/io_uart_txq.sv | 146 ++++++++++++++
 tb/tb_io_uart_txq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_txq.sv
// io_uart_txq -- transmit queue between the CPU IO port and the byte-wide
// UART emitter.
//
// CPU stores to the data word are queued in a DEPTH-entry FIFO and drained
// into a registered output stage (uart_data/uart_valid) that talks to the
// emitter with a valid/ready handshake. The status word exposes full/empty,
// a sticky overflow flag and the storage occupancy.
//
// Ports:
//   clk, resetn      system clock, asynchronous active-low reset
//   io_wr            IO write strobe (one cycle per store)
//   io_addr          IO byte address, word address = io_addr[15:2]
//   io_wdata         IO write data (data push uses [7:0])
//   io_rdata         IO read data, combinational from io_addr
//   uart_data        byte presented to the emitter (registered)
//   uart_valid       uart_data holds a byte (registered)
//   uart_ready       emitter accepts the presented byte this cycle
//   irq_empty        level: storage and output stage both empty
module io_uart_txq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [7:0]  uart_data,
  output logic        uart_valid,
  input  logic        uart_ready,
  output logic        irq_empty
);

  localparam int CW = AW + 1;

  // Status word layout as seen by software.
  typedef struct packed {
    logic [10:0] rsv_hi;
    logic [4:0]  count;
    logic [3:0]  rsv_mid;
    logic        overflow;
    logic        empty;
    logic        full;   // bit 9: "busy, do not write"
    logic [8:0]  rsv_lo;
  } status_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    uart_data_q, uart_data_d;
  logic          uart_valid_q, uart_valid_d;
  logic          overflow_q, overflow_d;

  logic [13:0]   wa;
  logic          push_req, clr_req;
  logic          full, empty, load, push_ok;
  status_t       status;

  assign wa       = io_addr[15:2];
  assign push_req = io_wr & wa[1];
  assign clr_req  = io_wr & wa[2];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0) & ~uart_valid_q;

  // The output stage refills whenever it is free or being emptied this cycle,
  // which keeps the line busy without bubbles while storage holds data.
  assign load = (~uart_valid_q | uart_ready) & (count_q != '0);

  // A full queue still accepts a push when a slot frees up in the same cycle.
  // In that case wr_ptr == rd_ptr; the read below samples the old byte before
  // the write lands at the edge.
  assign push_ok = push_req & (~full | load);

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    uart_data_d  = uart_data_q;
    uart_valid_d = uart_valid_q;
    overflow_d   = overflow_q;

    if (load) begin
      uart_data_d  = mem_q[rd_ptr_q];
      uart_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end else if (uart_valid_q & uart_ready) begin
      uart_valid_d = 1'b0;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);

    case ({push_ok, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen in one cycle.
    if (clr_req) overflow_d = 1'b0;
    if (push_req & ~push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      uart_data_q  <= 8'h00;
      uart_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      uart_data_q  <= uart_data_d;
      uart_valid_q <= uart_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= io_wdata[7:0];
  end

  always_comb begin
    status          = '0;
    status.count    = 5'(count_q);
    status.overflow = overflow_q;
    status.empty    = empty;
    status.full     = full;
  end

  assign io_rdata   = wa[2] ? status : 32'h0;
  assign uart_data  = uart_data_q;
  assign uart_valid = uart_valid_q;
  assign irq_empty  = empty;

  // Address/data bits outside the decode are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{io_addr[31:16], io_addr[1:0], wa[13:3], wa[0], io_wdata[31:8]};

endmodule

// File: tb/tb_io_uart_txq.sv
// Self-checking bench for io_uart_txq. A queue-based reference model tracks
// stored bytes, the output stage and the overflow flag; expected emitter
// traffic is collected by the model and compared with what the DUT presents
// at each handshake.
module tb_io_uart_txq;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        io_wr = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready = 1'b0;
  logic        irq_empty;

  io_uart_txq #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .resetn(resetn), .io_wr(io_wr), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .uart_data(uart_data),
    .uart_valid(uart_valid), .uart_ready(uart_ready), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model state.
  logic [7:0] mq[$];      // stored bytes, oldest first
  logic       mv;         // output stage occupied
  logic [7:0] md;         // output stage byte
  logic       movf;       // sticky overflow
  logic [7:0] exp_emit[$];
  logic [7:0] got_emit[$];

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[20:16] = 5'(mq.size());
    s[11]    = movf;
    s[10]    = (mq.size() == 0) && !mv;
    s[9]     = (mq.size() == DEPTH);
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    mv = 1'b0;
    md = 8'h00;
    movf = 1'b0;
  endtask

  // Drive one cycle and advance the model by the same edge.
  task automatic step(input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic rdy);
    logic push, clr, full, load, acc;
    io_wr = wr; io_addr = addr; io_wdata = wdata; uart_ready = rdy;
    push = wr & addr[3];
    clr  = wr & addr[4];
    full = (mq.size() == DEPTH);
    load = (!mv || rdy) && (mq.size() != 0);
    acc  = push && (!full || load);
    #1;
    if (mv && rdy) exp_emit.push_back(md);
    if (uart_valid && rdy) got_emit.push_back(uart_data);
    @(posedge clk);
    #1;
    cyc_n++;
    if (load) begin
      md = mq.pop_front();
      mv = 1'b1;
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    if (acc) mq.push_back(wdata[7:0]);
    movf = (push && !acc) || (movf && !clr);
    io_wr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0000_0400) begin
      errors++; $display("FAIL reset_status: got %h exp %h", io_rdata, 32'h0000_0400);
    end
    checks++;
    if (uart_valid !== 1'b0 || irq_empty !== 1'b1) begin
      errors++; $display("FAIL reset_flags: got valid=%b irq=%b exp valid=0 irq=1", uart_valid, irq_empty);
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'h08, 32'h41, 1'b0);
    checks++;
    if (uart_valid !== 1'b0) begin
      errors++; $display("FAIL single_no_forward: got valid=%b exp 0", uart_valid);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (uart_valid !== 1'b1 || uart_data !== 8'h41) begin
      errors++; $display("FAIL single_out: got valid=%b data=%h exp 1/41", uart_valid, uart_data);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (uart_valid !== 1'b1 || uart_data !== 8'h41) begin
      errors++; $display("FAIL single_hold: got valid=%b data=%h exp 1/41", uart_valid, uart_data);
    end
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0000_0000) begin
      errors++; $display("FAIL single_status: got %h exp %h", io_rdata, 32'h0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (uart_valid !== 1'b0 || irq_empty !== 1'b1) begin
      errors++; $display("FAIL single_drain: got valid=%b irq=%b exp 0/1", uart_valid, irq_empty);
    end
  endtask

  task automatic test_hello();
    logic [7:0] hello [5];
    int guard;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    got_emit.delete(); exp_emit.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h08, {24'h0, hello[i]}, (cyc_n % 10) == 9);
    guard = 0;
    while ((mq.size() != 0 || mv) && guard < 300) begin
      step(1'b0, 32'h0, 32'h0, (cyc_n % 10) == 9);
      guard++;
    end
    checks++;
    if (got_emit.size() != 5) begin
      errors++; $display("FAIL hello_count: got %0d exp 5", got_emit.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_emit[i] !== hello[i]) begin
          errors++; $display("FAIL hello_byte%0d: got %h exp %h", i, got_emit[i], hello[i]);
        end
      end
    end
    checks++;
    if (irq_empty !== 1'b1) begin
      errors++; $display("FAIL hello_irq: got %b exp 1", irq_empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h08, 32'h10 + i, 1'b0);
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0010_0200) begin
      errors++; $display("FAIL ovf_full: got %h exp %h", io_rdata, 32'h0010_0200);
    end
    step(1'b1, 32'h08, 32'hEE, 1'b0);
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0010_0A00) begin
      errors++; $display("FAIL ovf_set: got %h exp %h", io_rdata, 32'h0010_0A00);
    end
    checks++;
    if (uart_valid !== 1'b1 || uart_data !== 8'h10) begin
      errors++; $display("FAIL ovf_out: got valid=%b data=%h exp 1/10", uart_valid, uart_data);
    end
    step(1'b1, 32'h10, 32'h0, 1'b0);
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0010_0200) begin
      errors++; $display("FAIL ovf_clear: got %h exp %h", io_rdata, 32'h0010_0200);
    end
  endtask

  task automatic test_full_simul();
    int guard;
    got_emit.delete(); exp_emit.delete();
    step(1'b1, 32'h08, 32'h99, 1'b1);
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0010_0200) begin
      errors++; $display("FAIL full_simul_status: got %h exp %h", io_rdata, 32'h0010_0200);
    end
    checks++;
    if (uart_data !== 8'h11) begin
      errors++; $display("FAIL full_simul_data: got %h exp %h", uart_data, 8'h11);
    end
    guard = 0;
    while ((mq.size() != 0 || mv) && guard < 100) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      guard++;
    end
    checks++;
    if (got_emit.size() != 18 || got_emit != exp_emit || exp_emit[17] !== 8'h99) begin
      errors++; $display("FAIL full_simul_order: got %0d bytes exp 18 ending 99 (last got %h)",
                         got_emit.size(), got_emit.size() ? got_emit[$] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1'b1, 32'h08, 32'hA0 + i, 1'b0);
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0005_0000) begin
      errors++; $display("FAIL rstmid_pre: got %h exp %h", io_rdata, 32'h0005_0000);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (uart_valid !== 1'b0 || irq_empty !== 1'b1) begin
      errors++; $display("FAIL rstmid_async: got valid=%b irq=%b exp 0/1", uart_valid, irq_empty);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    io_addr = 32'h10;
    #1;
    checks++;
    if (io_rdata !== 32'h0000_0400) begin
      errors++; $display("FAIL rstmid_status: got %h exp %h", io_rdata, 32'h0000_0400);
    end
    got_emit.delete();
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
    checks++;
    if (got_emit.size() != 0 || uart_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_stale: got %0d bytes valid=%b exp 0/0", got_emit.size(), uart_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [4];
    logic        wr, rdy;
    logic [31:0] a, d;
    addrs = '{32'h08, 32'h10, 32'h0C, 32'h04};
    got_emit.delete(); exp_emit.delete();
    for (int i = 0; i < 600; i++) begin
      wr  = ($urandom_range(0, 99) < 60);
      a   = ($urandom_range(0, 9) < 7) ? 32'h08 : addrs[$urandom_range(0, 3)];
      d   = $urandom;
      // Phases of slow and fast draining so the queue both fills and empties.
      rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      io_addr = a;
      #1;
      checks++;
      if (io_rdata !== (a[4] ? exp_status() : 32'h0)) begin
        errors++; $display("FAIL rand_rdata@%0d: got %h exp %h", i, io_rdata, a[4] ? exp_status() : 32'h0);
      end
      step(wr, a, d, rdy);
      checks++;
      if (uart_valid !== mv || uart_data !== md || irq_empty !== ((mq.size() == 0) && !mv)) begin
        errors++; $display("FAIL rand_out@%0d: got v=%b d=%h irq=%b exp v=%b d=%h irq=%b",
                           i, uart_valid, uart_data, irq_empty, mv, md, (mq.size() == 0) && !mv);
      end
    end
    checks++;
    if (got_emit != exp_emit) begin
      errors++; $display("FAIL rand_stream: got %0d bytes exp %0d", got_emit.size(), exp_emit.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hello();
    test_overflow();
    test_full_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
